// File: rtl/output_layer_pkg.sv
// output_layer_pkg: shared definitions for the output_layer classifier.
//   - FSM state encoding
//   - log2 and width-derivation helpers
//   - saturation helper
// Optional feature macro used by the top: OUTLAYER_SCORES_EN.
package output_layer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAC    = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Ceiling log2 with a floor of 1, so a 2-entry index still has one bit.
  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int calc_bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  // Headroom: full product (2*BW) plus log2(HIDDEN_SZ) bits for the sum,
  // plus one for the bias term.
  function automatic int calc_acc_w(input int bw, input int aw);
    return 2 * bw + aw + 1;
  endfunction

  // Clamp a sign-extended value to the signed range of a bw-bit word.
  function automatic logic signed [127:0] sat(input logic signed [127:0] v,
                                               input int bw);
    logic signed [127:0] mx, mn;
    mx = (128'sd1 <<< (bw - 1)) - 128'sd1;
    mn = -mx - 128'sd1;
    if (v > mx)      return mx;
    else if (v < mn) return mn;
    else             return v;
  endfunction

endpackage

// File: rtl/output_layer_mac.sv
// outlayer_mac: one per-symbol serial multiply-accumulate lane.
//   clock, reset       : clock, async active-high reset
//   i_clear            : synchronous clear of the accumulator
//   i_load             : load acc = sign-extended bias <<< QM (wins over acc)
//   i_acc_en           : acc += w * h (full signed product)
//   i_bias, i_w, i_h   : signed Q(QN.QM) operands
//   o_acc              : accumulator value
module outlayer_mac #(
  parameter int BW    = 18,
  parameter int ACC_W = 41,
  parameter int QM    = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_acc_en,
  input  logic [BW-1:0]    i_bias,
  input  logic [BW-1:0]    i_w,
  input  logic [BW-1:0]    i_h,
  output logic [ACC_W-1:0] o_acc
);

  logic signed [2*BW-1:0] w_prod;
  logic [ACC_W-1:0]       r_acc;

  assign w_prod = $signed(i_w) * $signed(i_h);
  assign o_acc  = r_acc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_acc <= '0;
    else if (i_clear)  r_acc <= '0;
    else if (i_load)   r_acc <= {{(ACC_W-BW-QM){i_bias[BW-1]}}, i_bias, {QM{1'b0}}};
    else if (i_acc_en) r_acc <= r_acc + {{(ACC_W-2*BW){w_prod[2*BW-1]}}, w_prod};
  end

endmodule

// File: rtl/output_layer.sv
// output_layer: dense classifier after the LSTM layer.
//   scores = W_out*h + b computed serially over hidden elements (one MAC lane
//   per symbol), followed by a sequential argmax (ties keep lower index).
// Ports:
//   clock, reset            : clock, async active-high reset
//   layerOut, layerValid    : hidden vector h and its one-cycle valid
//   bias                    : per-symbol signed bias (static while busy)
//   wAddr, wData, wEn       : weight column write (accepted only in IDLE)
//   busy                    : classification in progress
//   dataoutReady, outputVec : one-cycle result pulse, argmax index (held)
//   scoresOut               : saturated acc>>>QM per symbol, only when
//                             OUTLAYER_SCORES_EN is defined
module output_layer
  import output_layer_pkg::*;
#(
  parameter  int HIDDEN_SZ          = 16,
  parameter  int NUM_OUTPUT_SYMBOLS = 2,
  parameter  int QN                 = 6,
  parameter  int QM                 = 11,
  localparam int BITWIDTH           = calc_bitwidth(QN, QM),
  localparam int OUTPUT_BITWIDTH    = log2(NUM_OUTPUT_SYMBOLS),
  localparam int ADDR_BITWIDTH      = log2(HIDDEN_SZ),
  localparam int ACC_W              = calc_acc_w(BITWIDTH, ADDR_BITWIDTH)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [HIDDEN_SZ*BITWIDTH-1:0]          layerOut,
  input  logic                                   layerValid,
  input  logic [NUM_OUTPUT_SYMBOLS*BITWIDTH-1:0] bias,
  input  logic [ADDR_BITWIDTH-1:0]               wAddr,
  input  logic [NUM_OUTPUT_SYMBOLS*BITWIDTH-1:0] wData,
  input  logic                                   wEn,
`ifdef OUTLAYER_SCORES_EN
  output logic [NUM_OUTPUT_SYMBOLS*BITWIDTH-1:0] scoresOut,
`endif
  output logic                                   busy,
  output logic                                   dataoutReady,
  output logic [OUTPUT_BITWIDTH-1:0]             outputVec
);

  localparam logic [ADDR_BITWIDTH-1:0]   LAST_K = ADDR_BITWIDTH'(HIDDEN_SZ - 1);
  localparam logic [OUTPUT_BITWIDTH-1:0] LAST_S = OUTPUT_BITWIDTH'(NUM_OUTPUT_SYMBOLS - 1);

  logic [HIDDEN_SZ-1:0][NUM_OUTPUT_SYMBOLS-1:0][BITWIDTH-1:0] r_w;
  logic [HIDDEN_SZ-1:0][BITWIDTH-1:0]                         r_h;
  logic [NUM_OUTPUT_SYMBOLS-1:0][ACC_W-1:0]                   w_acc;
  state_t                       r_state;
  logic [ADDR_BITWIDTH-1:0]     r_k;
  logic [OUTPUT_BITWIDTH-1:0]   r_s, r_best, w_best_nxt;
  logic                         w_load, w_acc_en, w_clear, w_last_cmp;

  assign w_load     = (r_state == ST_IDLE) && layerValid;
  assign w_acc_en   = (r_state == ST_MAC);
  assign w_clear    = (r_state == ST_DONE);
  assign w_last_cmp = (r_state == ST_ARGMAX) && (r_s == LAST_S);
  // Strict compare: an equal score never displaces the lower index.
  assign w_best_nxt = ($signed(w_acc[r_s]) > $signed(w_acc[r_best])) ? r_s : r_best;

  // Weight store: column per hidden index, async read by the MAC lanes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                            r_w <= '0;
    else if (wEn && r_state == ST_IDLE)   r_w[wAddr] <= wData;
  end

  for (genvar s = 0; s < NUM_OUTPUT_SYMBOLS; s++) begin : g_mac
    outlayer_mac #(.BW(BITWIDTH), .ACC_W(ACC_W), .QM(QM)) u_mac (
      .clock    (clock),
      .reset    (reset),
      .i_clear  (w_clear),
      .i_load   (w_load),
      .i_acc_en (w_acc_en),
      .i_bias   (bias[s*BITWIDTH +: BITWIDTH]),
      .i_w      (r_w[r_k][s]),
      .i_h      (r_h[r_k]),
      .o_acc    (w_acc[s])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_h          <= '0;
      r_k          <= '0;
      r_s          <= '0;
      r_best       <= '0;
      busy         <= 1'b0;
      dataoutReady <= 1'b0;
      outputVec    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (layerValid) begin
          r_h     <= layerOut;
          r_k     <= '0;
          busy    <= 1'b1;
          r_state <= ST_MAC;
        end
        ST_MAC: begin
          r_k <= r_k + ADDR_BITWIDTH'(1);
          if (r_k == LAST_K) begin
            r_best  <= '0;
            r_s     <= OUTPUT_BITWIDTH'(1);
            r_state <= ST_ARGMAX;
          end
        end
        ST_ARGMAX: begin
          r_best <= w_best_nxt;
          r_s    <= r_s + OUTPUT_BITWIDTH'(1);
          if (r_s == LAST_S) begin
            outputVec    <= w_best_nxt;
            dataoutReady <= 1'b1;
            busy         <= 1'b0;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          dataoutReady <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef OUTLAYER_SCORES_EN
  logic signed [ACC_W-1:0]                   w_sh [NUM_OUTPUT_SYMBOLS];
  logic [NUM_OUTPUT_SYMBOLS-1:0][BITWIDTH-1:0] r_scores;

  for (genvar s = 0; s < NUM_OUTPUT_SYMBOLS; s++) begin : g_sh
    assign w_sh[s] = $signed(w_acc[s]) >>> QM;
  end

  // Accumulators are frozen during ARGMAX, so capture on the result edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_scores <= '0;
    else if (w_last_cmp)
      for (int s = 0; s < NUM_OUTPUT_SYMBOLS; s++)
        r_scores[s] <= BITWIDTH'(sat(128'(w_sh[s]), BITWIDTH));
  end

  assign scoresOut = r_scores;
`endif

endmodule
